// File: rtl/boot_pkg.sv
// Shared types and default protocol constants for the UART boot loader.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      DATA,
      CSUM,
      RESP,
      WAIT_TX
   } state_t;

   localparam logic [31:0] MAGIC_DEFAULT = 32'hB007_10AD;
   localparam logic [31:0] ACK_DEFAULT   = 32'h0000_00AC;
   localparam logic [31:0] NAK_DEFAULT   = 32'h0000_00EE;

endpackage

// File: rtl/boot_timeout.sv
// Inter-word watchdog: reloads on clr or while disabled, counts down while enabled,
// and pulses expire on the CYCLES-th consecutive enabled cycle without a clear.
module boot_timeout #(
   parameter int unsigned CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr || !en) begin
         count <= CW'(CYCLES);
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign expire = en && !clr && (count == CW'(1));

endmodule

// File: rtl/uart_boot_loader.sv
// Boot command engine: parses MAGIC/addr/len/data/checksum frames into instruction
// memory writes, answers with one ACK/NAK word and gates the core reset.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W         = 12,
   parameter logic [31:0] MAGIC          = MAGIC_DEFAULT,
   parameter logic [31:0] ACK_WORD       = ACK_DEFAULT,
   parameter logic [31:0] NAK_WORD       = NAK_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       data_recv_word,
   input  logic              new_rx_word,
   output logic [31:0]       data_send_word,
   output logic              ena_tx_word,
   input  logic              tx_done_word,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              boot_done,
   output logic              boot_error
);

   localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   idx_inc;
   logic [31:0]       checksum;
   logic              resp_ok;
   logic [32:0]       end_addr;
   logic              range_err;
   logic              last_word;
   logic              timer_en;
   logic              expire;

   logic start_load, latch_addr, latch_len, write_word, check_csum;
   logic send_reply, finish_reply;

   // End address is formed in 33 bits so an oversized N cannot wrap into range.
   assign end_addr  = 33'(start_addr) + 33'(data_recv_word);
   assign range_err = (data_recv_word == '0) || (end_addr > DEPTH);
   assign idx_inc   = idx + (ADDR_W + 1)'(1);
   assign last_word = (idx_inc == len);
   assign timer_en  = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);

   boot_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (new_rx_word),
      .en     (timer_en),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (new_rx_word && data_recv_word == MAGIC) state_nxt = ADDR;
         ADDR:    if (new_rx_word) state_nxt = LEN;
         LEN:     if (new_rx_word) state_nxt = range_err ? RESP : DATA;
         DATA:    if (new_rx_word && last_word) state_nxt = CSUM;
         CSUM:    if (new_rx_word) state_nxt = RESP;
         RESP:    state_nxt = WAIT_TX;
         WAIT_TX: if (tx_done_word) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (expire) state_nxt = IDLE;
   end

   always_comb begin
      start_load   = 1'b0;
      latch_addr   = 1'b0;
      latch_len    = 1'b0;
      write_word   = 1'b0;
      check_csum   = 1'b0;
      send_reply   = 1'b0;
      finish_reply = 1'b0;
      unique case (state)
         IDLE:    start_load   = new_rx_word && (data_recv_word == MAGIC);
         ADDR:    latch_addr   = new_rx_word;
         LEN:     latch_len    = new_rx_word;
         DATA:    write_word   = new_rx_word;
         CSUM:    check_csum   = new_rx_word;
         RESP:    send_reply   = 1'b1;
         WAIT_TX: finish_reply = tx_done_word;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rst        <= 1'b1;
         ena_tx_word    <= 1'b0;
         data_send_word <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         boot_done      <= 1'b0;
         boot_error     <= 1'b0;
         checksum       <= '0;
         start_addr     <= '0;
         len            <= '0;
         idx            <= '0;
         resp_ok        <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         boot_done  <= 1'b0;
         boot_error <= 1'b0;
         if (start_load) begin
            cpu_rst  <= 1'b1;
            checksum <= '0;
         end
         if (latch_addr) start_addr <= data_recv_word[ADDR_W-1:0];
         if (latch_len) begin
            len <= data_recv_word[ADDR_W:0];
            idx <= '0;
            if (range_err) resp_ok <= 1'b0;
         end
         if (write_word) begin
            mem_we    <= 1'b1;
            mem_addr  <= start_addr + idx[ADDR_W-1:0];
            mem_wdata <= data_recv_word;
            checksum  <= checksum + data_recv_word;
            idx       <= idx_inc;
         end
         if (check_csum) resp_ok <= (data_recv_word == checksum);
         if (send_reply) begin
            data_send_word <= resp_ok ? ACK_WORD : NAK_WORD;
            ena_tx_word    <= 1'b1;
         end
         if (finish_reply) begin
            ena_tx_word <= 1'b0;
            if (resp_ok) begin
               boot_done <= 1'b1;
               cpu_rst   <= 1'b0;
            end else begin
               boot_error <= 1'b1;
            end
         end
         if (expire) boot_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frame table plus hand-built timeout, handshake and reset sequences.
module tb_uart_boot_loader;
   import boot_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned TO = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   data_recv_word = '0;
   logic          new_rx_word = 1'b0;
   logic [31:0]   data_send_word;
   logic          ena_tx_word;
   logic          tx_done_word = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst;
   logic          boot_done;
   logic          boot_error;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .ADDR_W         (AW),
      .MAGIC          (32'hB007_10AD),
      .ACK_WORD       (32'h0000_00AC),
      .NAK_WORD       (32'h0000_00EE),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_recv_word (data_recv_word),
      .new_rx_word    (new_rx_word),
      .data_send_word (data_send_word),
      .ena_tx_word    (ena_tx_word),
      .tx_done_word   (tx_done_word),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .cpu_rst        (cpu_rst),
      .boot_done      (boot_done),
      .boot_error     (boot_error)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      string       name;
      logic [31:0] start;
      logic [31:0] len;
      logic [31:0] pat;
      bit          csum_ok;
      logic [31:0] exp_reply;
      int unsigned exp_writes;
      bit          exp_cpu_rst;
   } vec_t;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   wr_t         exp_wr[$];
   logic [31:0] exp_reply_q[$];
   int unsigned n_writes = 0;
   int unsigned n_replies = 0;
   int unsigned tx_delay = 3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Host side of the reply handshake: acknowledge each reply after tx_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (ena_tx_word && !tx_done_word) begin
            repeat (tx_delay) @(negedge clk);
            tx_done_word = 1'b1;
            @(negedge clk);
            tx_done_word = 1'b0;
         end
      end
   end

   // Scoreboard monitor for memory writes and reply words.
   initial begin
      logic        prev_ena = 1'b0;
      logic [31:0] cur_reply = '0;
      int unsigned ena_cycles = 0;
      bit          held_ok = 1'b1;
      wr_t         w;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            n_writes++;
            if (exp_wr.size() == 0) begin
               check("unexpected_write", {20'b0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               w = exp_wr.pop_front();
               check("write_addr", {20'b0, mem_addr}, {20'b0, w.addr});
               check("write_data", mem_wdata, w.data);
            end
         end
         if (ena_tx_word && !prev_ena) begin
            n_replies++;
            cur_reply  = data_send_word;
            ena_cycles = 1;
            held_ok    = 1'b1;
            if (exp_reply_q.size() == 0) check("unexpected_reply", data_send_word, 32'hFFFF_FFFF);
            else check("reply_word", data_send_word, exp_reply_q.pop_front());
         end else if (ena_tx_word) begin
            ena_cycles++;
            if (data_send_word !== cur_reply) held_ok = 1'b0;
         end
         if (!ena_tx_word && prev_ena) begin
            check("ena_tx_cycles", ena_cycles, tx_delay + 1);
            check("reply_held", {31'b0, held_ok}, 32'd1);
         end
         prev_ena = ena_tx_word;
      end
   end

   task automatic send_word(input logic [31:0] w, input int unsigned gap);
      data_recv_word = w;
      new_rx_word    = 1'b1;
      @(negedge clk);
      new_rx_word    = 1'b0;
      data_recv_word = '0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_rst"}, cpu_rst, 1);
      check({tag, "_ena_tx"}, ena_tx_word, 0);
      check({tag, "_send_word"}, data_send_word, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, {20'b0, mem_addr}, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_boot_done"}, boot_done, 0);
      check({tag, "_boot_error"}, boot_error, 0);
   endtask

   task automatic run_frame(input vec_t v);
      int unsigned w0 = n_writes;
      int unsigned r0 = n_replies;
      int unsigned cnt = 0;
      logic [31:0] sum = '0;
      logic [31:0] d;
      bit          range_ok;
      range_ok = (v.len != 0) && (v.start + v.len <= 32'd4096);
      exp_reply_q.push_back(v.exp_reply);
      send_word(32'hB007_10AD, 1);
      check({v.name, "_cpu_rst_on_magic"}, cpu_rst, 1);
      send_word(v.start, 0);
      send_word(v.len, 1);
      if (range_ok) begin
         for (int unsigned i = 0; i < v.len; i++) begin
            d = v.pat * (i + 1);
            exp_wr.push_back('{addr: AW'(v.start + i), data: d});
            sum += d;
            send_word(d, i % 2);
         end
         send_word(v.csum_ok ? sum : 32'h0, 0);
      end
      while (!(boot_done || boot_error) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      check({v.name, "_end_seen"}, {31'b0, cnt < 3000}, 1);
      check({v.name, "_boot_done"}, boot_done, (v.exp_reply == 32'hAC) ? 1 : 0);
      check({v.name, "_boot_error"}, boot_error, (v.exp_reply == 32'hAC) ? 0 : 1);
      check({v.name, "_cpu_rst"}, cpu_rst, v.exp_cpu_rst);
      @(negedge clk);
      check({v.name, "_ena_low"}, ena_tx_word, 0);
      check({v.name, "_writes"}, n_writes - w0, v.exp_writes);
      check({v.name, "_replies"}, n_replies - r0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[6];
      int unsigned cnt;
      int unsigned r0;

      vecs[0] = '{"good_load",  32'h010, 32'd4, 32'h1111_1111, 1'b1, 32'hAC, 4, 1'b0};
      vecs[1] = '{"bad_csum",   32'h010, 32'd4, 32'h1111_1111, 1'b0, 32'hEE, 4, 1'b1};
      vecs[2] = '{"range_over", 32'hFFE, 32'd4, 32'h0102_0304, 1'b1, 32'hEE, 0, 1'b1};
      vecs[3] = '{"len_zero",   32'h020, 32'd0, 32'h0102_0304, 1'b1, 32'hEE, 0, 1'b1};
      vecs[4] = '{"top_edge",   32'hFFC, 32'd4, 32'h0F0F_1234, 1'b1, 32'hAC, 4, 1'b0};
      vecs[5] = '{"single",     32'h100, 32'd1, 32'h5A5A_5A5A, 1'b1, 32'hAC, 1, 1'b0};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Non-MAGIC words in IDLE must be dropped without effect.
      send_word(32'h1234_5678, 2);
      send_word(32'hDEAD_BEEF, 2);
      check("ignored_replies", n_replies, 0);
      check("ignored_writes", n_writes, 0);
      check("ignored_cpu_rst", cpu_rst, 1);

      for (int unsigned k = 0; k < 6; k++) run_frame(vecs[k]);

      // Slow host acknowledgement: reply must stay up for the whole wait.
      tx_delay = 500;
      vecs[0].name = "slow_tx";
      run_frame(vecs[0]);
      tx_delay = 3;

      // Stall after two data words: watchdog abort with no reply.
      r0 = n_replies;
      send_word(32'hB007_10AD, 0);
      check("to_cpu_rst_on_magic", cpu_rst, 1);
      send_word(32'h100, 0);
      send_word(32'd4, 0);
      exp_wr.push_back('{addr: 12'h100, data: 32'hCAFE_0001});
      exp_wr.push_back('{addr: 12'h101, data: 32'hCAFE_0002});
      send_word(32'hCAFE_0001, 0);
      send_word(32'hCAFE_0002, 0);
      cnt = 0;
      while (!boot_error && cnt < 1100) begin
         @(negedge clk);
         cnt++;
      end
      check("to_cycles", cnt, TO);
      check("to_boot_done", boot_done, 0);
      check("to_cpu_rst", cpu_rst, 1);
      repeat (5) @(negedge clk);
      check("to_no_reply", n_replies - r0, 0);
      vecs[0].name = "after_timeout";
      run_frame(vecs[0]);

      // Reset in the middle of DATA.
      send_word(32'hB007_10AD, 0);
      send_word(32'h200, 0);
      send_word(32'd4, 0);
      exp_wr.push_back('{addr: 12'h200, data: 32'h7777_0001});
      send_word(32'h7777_0001, 0);
      check("mid_we_seen", mem_we, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      @(negedge clk);
      vecs[5].name = "after_rst";
      run_frame(vecs[5]);

      check("pending_writes", exp_wr.size(), 0);
      check("pending_replies", exp_reply_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
